// File: rtl/fifo_read_port.sv
// fifo_read_port: read-side FIFO controller turning BRAM words into a valid/ready stream.
// Ports: clock/reset (sync, active-high); wr_ptr in, rd_ptr out (ADDR_WIDTH+1 bits, MSB = wrap);
//        r_en/read_addr/read_data drive the BRAM read port (1-cycle latency);
//        flush discards unread data; out_valid/out_ready/out_data form the output stream;
//        mem_level = wr_ptr - rd_ptr; overrun is the sticky level error flag.
// Optional: define FIFO_RD_OVERRUN_CHECK_EN to enable overrun detection (otherwise tied 0).
module fifo_read_port #(
    parameter int DEPTH      = 32,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH:0]   rd_ptr,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [WIDTH-1:0]      read_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ADDR_WIDTH:0]   mem_level,
    output logic                  overrun
);
    if (DEPTH != 2 ** ADDR_WIDTH) begin : g_depth_check
        $error("DEPTH must equal 2**ADDR_WIDTH");
    end
    logic [ADDR_WIDTH:0] rd_ptr_q;
    logic                inflight_q;
    logic [1:0]          count_q, count_d, kept;
    logic [WIDTH-1:0]    q0_q, q1_q, q0_d, q1_d;
    logic                pop;
    assign out_valid = count_q != 2'd0;
    assign pop       = out_valid & out_ready;
    assign out_data  = q0_q;
    assign rd_ptr    = rd_ptr_q;
    assign read_addr = rd_ptr_q[ADDR_WIDTH-1:0];
    assign mem_level = wr_ptr - rd_ptr_q;
    // entries left after this cycle's pop; a new read is allowed only if the
    // queue can still hold it once the in-flight word has landed
    assign kept = count_q - {1'b0, pop};
    assign r_en = !reset && !flush && (rd_ptr_q != wr_ptr) &&
                  (({1'b0, kept} + {2'b0, inflight_q}) < 3'd2);
    // the arriving word lands behind whatever remains after the pop
    always_comb begin
        q0_d    = (inflight_q && kept == 2'd0) ? read_data : (pop ? q1_q : q0_q);
        q1_d    = (inflight_q && kept != 2'd0) ? read_data : q1_q;
        count_d = kept + {1'b0, inflight_q};
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            q0_q       <= '0;
            q1_q       <= '0;
        end else if (flush) begin
            rd_ptr_q   <= wr_ptr;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
        end else begin
            rd_ptr_q   <= rd_ptr_q + (ADDR_WIDTH + 1)'(r_en);
            inflight_q <= r_en;
            count_q    <= count_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
        end
    end
`ifdef FIFO_RD_OVERRUN_CHECK_EN
    logic overrun_q;
    always_ff @(posedge clock) begin
        if (reset)
            overrun_q <= 1'b0;
        else if (mem_level > (ADDR_WIDTH + 1)'(DEPTH))
            overrun_q <= 1'b1;
    end
    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif
endmodule

// File: doc/fifo_read_port.md
# fifo_read_port

Read-side controller of the FIFO: consumes the write pointer published by the write side and drives the read port of `bram` (`r_en`, `read_addr`, 1-cycle registered `read_data`). It presents the stored words as a valid/ready stream and returns its read pointer to the write side for full detection. A 2-entry output queue absorbs the BRAM read latency and sustains one word per cycle under continuous `out_ready`.

## Interface
- `DEPTH`, 32, BRAM words; must equal 2**ADDR_WIDTH
- `WIDTH`, 8, data word width
- `ADDR_WIDTH`, 5, BRAM address width; pointers are ADDR_WIDTH+1 bits (MSB = wrap bit)

- `clock`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `wr_ptr`  in  ADDR_WIDTH+1  write pointer from write side, same clock domain
- `rd_ptr`  out  ADDR_WIDTH+1  read pointer to write side; counts words issued to BRAM
- `r_en`  out  1  BRAM read enable
- `read_addr`  out  ADDR_WIDTH  BRAM read address = `rd_ptr[ADDR_WIDTH-1:0]`
- `read_data`  in  WIDTH  BRAM read data, valid the cycle after `r_en`
- `flush`  in  1  synchronous discard of all unread data
- `out_valid`  out  1  `out_data` holds a word
- `out_ready`  in  1  consumer accepts word when `out_valid & out_ready`
- `out_data`  out  WIDTH  head word of output queue
- `mem_level`  out  ADDR_WIDTH+1  `wr_ptr - rd_ptr` modulo 2**(ADDR_WIDTH+1)
- `overrun`  out  1  sticky error flag (see Configuration)

## Operation
- State: `rd_ptr`; `inflight` (1 bit, read issued last cycle); output queue `q[0:1]` with `count` 0..2, head at `q[0]`.
- `pop = out_valid & out_ready`; `out_valid = (count != 0)`; `out_data = q[0]`.
- Issue condition: `r_en = !reset & !flush & (rd_ptr != wr_ptr) & (count + inflight - pop < 2)`. Combinational path `out_ready -> r_en` is intended.
- On issue: `rd_ptr <= rd_ptr + 1` (wraps naturally through MSB), `inflight <= 1`; otherwise `inflight <= 0`.
- When `inflight`: `read_data` is pushed into the queue at the edge ending that cycle; push and pop in the same cycle leave `count` unchanged and shift correctly (pushed word lands behind remaining head).
- Push when `count == 2` never happens; bench asserts it.
- Empty: `rd_ptr == wr_ptr` -> no issue. Full (write side): `mem_level == DEPTH`; reader needs no special handling, issue continues.
- `flush`: at the edge, `rd_ptr <= wr_ptr` (current input value), `count <= 0`, `inflight <= 0`; word arriving on `read_data` that cycle is dropped. `r_en = 0` during flush. `flush` overrides a simultaneous pop (word counted as consumed and discarded).
- Reset mid-operation: same as flush except `rd_ptr <= 0`; write side must be reset in the same cycle.

## Timing
- Reset values: `rd_ptr = 0`, `r_en = 0`, `read_addr = 0`, `out_valid = 0`, `out_data = 0`, `mem_level = wr_ptr` (combinational), `overrun = 0`, `count = 0`, `inflight = 0`.
- Latency: `wr_ptr` advances, visible in cycle C -> `r_en = 1` in C -> `read_data` valid C+1 -> `out_valid = 1` in C+2.
- Throughput: 1 word/cycle with `out_ready` held high and `mem_level >= 1`.
- Backpressure: with `out_ready = 0`, at most 2 words leave the BRAM beyond those consumed; `r_en` drops once `count + inflight == 2`.
- `out_data` stable while `out_valid & !out_ready`.

## Configuration
- `FIFO_RD_OVERRUN_CHECK_EN` defined: `overrun` sets (sticky until reset) in the cycle after `mem_level > DEPTH` is observed; cleared only by `reset`, not by `flush`.
- Not defined: no compare logic; `overrun` tied to 0.

## Test plan
- Reset, then `wr_ptr` 0->1 with BRAM word 0xA5 at address 0 -> `r_en` same cycle, `out_valid` 2 cycles later with `out_data = 0xA5`, `rd_ptr = 1`.
- `wr_ptr = 32` (full), `out_ready = 1` -> 32 consecutive beats 0x00..0x1F, one per cycle, `rd_ptr` wraps to 32 (wrap bit set, address 0), `mem_level = 0`.
- 8 words stored, `out_ready = 0` for 10 cycles -> exactly 2 reads issued, `out_data` held at first word; release -> remaining 6 follow back-to-back, order preserved.
- `out_ready` toggling 1,0,1,0 over 16 words -> no loss, no duplication, `count` never exceeds 2.
- `flush` with 5 words pending and one in flight -> next cycle `out_valid = 0`, `rd_ptr = wr_ptr`, `mem_level = 0`; new write afterward delivered normally.
- With macro defined, force `wr_ptr - rd_ptr = 33` -> `overrun = 1` next cycle, stays 1 through `flush`, clears on `reset`; without macro `overrun` stays 0.
